// File: rtl/uart_rx_latch.sv
// 8N1 UART receiver. The serial line passes through a 2-flop synchroniser, then each good byte is
// latched and handed off with a valid/ack handshake. Framing and overrun errors are flagged.
module uart_rx_latch #(
    parameter int CLKS_PER_BIT = 87,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    output logic       uart_rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_busy;
    logic             r_frame_err;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_overrun;

    logic             w_rxs;
    logic             w_stop_good;

    assign w_rxs       = r_sync2;
    assign w_stop_good = (r_state == S_STOP) && (r_cnt == CNT_BIT_END) && w_rxs;

    // Preset to idle-high so that releasing reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF_END) begin
                        r_cnt <= '0;
                        if (!w_rxs) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_BIT_END) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leave at mid stop bit so that a back-to-back start edge is still seen in IDLE.
                    if (r_cnt == CNT_BIT_END) begin
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_frame_err <= !w_rxs;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A new byte beats a simultaneous ack. Overrun is raised only when the held byte was never consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_stop_good) begin
            r_data    <= r_shift;
            r_valid   <= 1'b1;
            r_overrun <= !rx_ack && (r_valid || r_overrun);
        end else if (rx_ack) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_overrun   = r_overrun;
    assign rx_frame_err = r_frame_err;
    assign uart_rx_busy = r_busy;

endmodule

// File: tb/tb_uart_rx_latch.sv
// Self-checking bench for uart_rx_latch. It uses directed vector tables, hand-written corner cases,
// and random frames compared against a byte-level reference model.
module tb_uart_rx_latch;

    localparam int C = 16;
    localparam int H = C / 2;

    logic       clk;
    logic       reset;
    logic       uart_rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       uart_rx_busy;

    int n_chk  = 0;
    int n_fail = 0;
    int ferr_cnt = 0;

    uart_rx_latch #(.CLKS_PER_BIT(C)) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rxd     (uart_rxd),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
        .uart_rx_busy (uart_rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each high cycle of the framing-error output adds one to the count.
    always @(negedge clk) if (rx_frame_err === 1'b1) ferr_cnt++;

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        logic       ack;
        logic [7:0] exp_dat;
        logic       exp_vld;
        logic       exp_ovr;
        int         exp_ferr;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a clock edge. The line falls immediately and each bit lasts C cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle(C);
            uart_rxd = b[i];
        end
        idle(C);
        uart_rxd = stop_bit;
        idle(C);
        uart_rxd = 1'b1;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (rx_valid !== 1'b1 && n < 400) begin
            idle(1);
            n++;
        end
        chk({nm, "_timeout"}, {31'd0, rx_valid}, 32'd1);
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        idle(1);
        rx_ack = 1'b0;
    endtask

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovr;
    int         m_ferr;

    initial begin
        int lat;
        int busy_low;
        int f0;
        logic [7:0] rb;
        logic       rs;
        logic       ra;

        reset = 1'b1;
        uart_rxd = 1'b1;
        rx_ack = 1'b0;
        tbl[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 0};
        tbl[1] = '{8'h12, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 0};
        tbl[2] = '{8'h34, 1'b1, 1'b1, 8'h34, 1'b1, 1'b1, 0};
        tbl[3] = '{8'h55, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0, 1};
        tbl[4] = '{8'h66, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 0};
        tbl[5] = '{8'h77, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 0};

        idle(3);
        chk("rst_data",  {24'd0, rx_data}, 32'h00);
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_ovr",   {31'd0, rx_overrun}, 32'd0);
        chk("rst_ferr",  {31'd0, rx_frame_err}, 32'd0);
        chk("rst_busy",  {31'd0, uart_rx_busy}, 32'd0);
        reset = 1'b0;
        idle(5);

        // First byte: exact latency, and busy held for the whole frame.
        // lat counts edges from the one just before the line falls. The first edge that sees the
        // fall is edge 1, so the expected count is 1 + (2 + H + 9*C).
        f0 = ferr_cnt;
        lat = 0;
        busy_low = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (rx_valid !== 1'b1 && lat < 300) begin
                    idle(1);
                    lat++;
                    if (lat >= 3 && lat <= 2 + H + 9 * C && uart_rx_busy !== 1'b1) busy_low++;
                end
            end
        join
        chk("a5_latency", lat, 1 + 2 + H + 9 * C);
        chk("a5_busy_gaps", busy_low, 0);
        chk("a5_data", {24'd0, rx_data}, 32'hA5);
        chk("a5_ferr", ferr_cnt - f0, 0);
        do_ack();
        chk("a5_ack_valid", {31'd0, rx_valid}, 32'd0);
        idle(4);

        for (int i = 0; i < 6; i++) begin
            f0 = ferr_cnt;
            send_frame(tbl[i].dat, tbl[i].stop);
            idle(2);
            chk($sformatf("tbl%0d_data", i), {24'd0, rx_data}, {24'd0, tbl[i].exp_dat});
            chk($sformatf("tbl%0d_valid", i), {31'd0, rx_valid}, {31'd0, tbl[i].exp_vld});
            chk($sformatf("tbl%0d_ovr", i), {31'd0, rx_overrun}, {31'd0, tbl[i].exp_ovr});
            chk($sformatf("tbl%0d_ferr", i), ferr_cnt - f0, tbl[i].exp_ferr);
            if (tbl[i].ack) begin
                do_ack();
                chk($sformatf("tbl%0d_ack_valid", i), {31'd0, rx_valid}, 32'd0);
                chk($sformatf("tbl%0d_ack_ovr", i), {31'd0, rx_overrun}, 32'd0);
            end
            idle(20);
        end

        // Ack lands on the very edge that latches 0x9A while 0x77 is still pending.
        fork
            send_frame(8'h9A, 1'b1);
            begin
                idle(2 + H + 9 * C);
                rx_ack = 1'b1;
                idle(1);
                rx_ack = 1'b0;
                chk("tie_data", {24'd0, rx_data}, 32'h9A);
                chk("tie_valid", {31'd0, rx_valid}, 32'd1);
                chk("tie_ovr", {31'd0, rx_overrun}, 32'd0);
            end
        join
        do_ack();
        idle(5);

        // Two frames with no idle time between them, each acked before the next one arrives.
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                wait_valid("b2b0");
                chk("b2b0_data", {24'd0, rx_data}, 32'h00);
                chk("b2b0_ovr", {31'd0, rx_overrun}, 32'd0);
                do_ack();
                wait_valid("b2b1");
                chk("b2b1_data", {24'd0, rx_data}, 32'hFF);
                chk("b2b1_ovr", {31'd0, rx_overrun}, 32'd0);
                do_ack();
            end
        join
        idle(5);

        // A 4-cycle low glitch is rejected at the mid-start sample.
        f0 = ferr_cnt;
        uart_rxd = 1'b0;
        idle(4);
        uart_rxd = 1'b1;
        chk("glitch_busy_seen", {31'd0, uart_rx_busy}, 32'd1);
        idle(40);
        chk("glitch_busy", {31'd0, uart_rx_busy}, 32'd0);
        chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
        chk("glitch_ferr", ferr_cnt - f0, 0);

        // Reset part-way through a frame, while a byte is being held.
        send_frame(8'h42, 1'b1);
        idle(3);
        chk("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
        uart_rxd = 1'b0;
        idle(C);
        uart_rxd = 1'b1;
        idle(2 * C);
        reset = 1'b1;
        idle(1);
        chk("mid_rst_data", {24'd0, rx_data}, 32'h00);
        chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, uart_rx_busy}, 32'd0);
        chk("mid_rst_ferr", {31'd0, rx_frame_err}, 32'd0);
        reset = 1'b0;
        idle(3 * C);
        chk("post_rst_busy", {31'd0, uart_rx_busy}, 32'd0);
        chk("post_rst_valid", {31'd0, rx_valid}, 32'd0);
        send_frame(8'h81, 1'b1);
        idle(2);
        chk("post_rst_data", {24'd0, rx_data}, 32'h81);
        chk("post_rst_vld", {31'd0, rx_valid}, 32'd1);
        do_ack();
        idle(5);

        // Random frames checked against a byte-level model of latch, overrun and ack.
        m_data = rx_data === 8'h81 ? 8'h81 : 8'h81;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        m_ferr = ferr_cnt;
        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 4) != 0);
            ra = 1'($urandom_range(0, 1));
            send_frame(rb, rs);
            if (rs) begin
                if (m_valid) m_ovr = 1'b1;
                m_data = rb;
                m_valid = 1'b1;
            end else begin
                m_ferr++;
            end
            idle(1);
            chk($sformatf("rnd%0d_data", i), {24'd0, rx_data}, {24'd0, m_data});
            chk($sformatf("rnd%0d_valid", i), {31'd0, rx_valid}, {31'd0, m_valid});
            chk($sformatf("rnd%0d_ovr", i), {31'd0, rx_overrun}, {31'd0, m_ovr});
            chk($sformatf("rnd%0d_ferr", i), ferr_cnt, m_ferr);
            if (ra) begin
                do_ack();
                m_valid = 1'b0;
                m_ovr = 1'b0;
            end
            // After a low stop bit the receiver briefly restarts, so the line needs extra idle time.
            idle(rs ? $urandom_range(0, 20) : 12 + $urandom_range(0, 8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
